// File: rtl/cordic_pkg.sv
// Shared definitions for the iterative CORDIC engine: mode encodings,
// controller states and the parameter-independent arctangent table.
package cordic_pkg;

  localparam logic ROT = 1'b0;
  localparam logic VEC = 1'b1;

  // Fractional bits at which the arctangent table is stored.
  localparam int ATAN_FRAC = 24;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // atan(2^-i) in degrees with 24 fractional bits, i = 0..15.
  function automatic logic [31:0] atanDeg24(input logic [3:0] idx);
    logic [31:0] val;
    case (idx)
      4'd0:    val = 32'd754974720;
      4'd1:    val = 32'd445687602;
      4'd2:    val = 32'd235489088;
      4'd3:    val = 32'd119537938;
      4'd4:    val = 32'd60000934;
      4'd5:    val = 32'd30029717;
      4'd6:    val = 32'd15018523;
      4'd7:    val = 32'd7509720;
      4'd8:    val = 32'd3754917;
      4'd9:    val = 32'd1877466;
      4'd10:   val = 32'd938734;
      4'd11:   val = 32'd469367;
      4'd12:   val = 32'd234684;
      4'd13:   val = 32'd117342;
      4'd14:   val = 32'd58671;
      default: val = 32'd29336;
    endcase
    return val;
  endfunction

  // A quarter turn expressed with the given number of fractional bits.
  function automatic int deg90(input int frac);
    return 90 << frac;
  endfunction

endpackage

// File: rtl/cordic_atan_rom.sv
// Combinational arctangent lookup: returns atan(2^-count) in degrees,
// rescaled from the 24-bit table precision to the angle datapath format.
module cordic_atan_rom
  import cordic_pkg::*;
#(
  parameter int ANGLE_W    = 18,
  parameter int ANGLE_FRAC = 8,
  parameter int CNT_W      = 4
) (
  input  logic [CNT_W-1:0]  count_i,
  output logic [ANGLE_W:0]  atan_o
);

  localparam int ZW    = ANGLE_W + 1;
  localparam int SHIFT = ATAN_FRAC - ANGLE_FRAC;

  logic [3:0] idx;

  // Table lookup with truncation down to the datapath fraction width.
  always_comb begin
    idx    = 4'(count_i);
    atan_o = ZW'(atanDeg24(idx) >> SHIFT);
  end

endmodule

// File: rtl/cordic_iter.sv
// Iterative circular CORDIC engine, one micro-rotation per clock.
// Rotation mode drives the angle to zero, vectoring mode drives y to zero.
// Inputs are quadrant pre-rotated so the full +/-180 degree range converges;
// outputs carry the uncompensated CORDIC gain and are saturated.
module cordic_iter
  import cordic_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int ANGLE_W    = 18,
  parameter int ANGLE_FRAC = 8,
  parameter int ITER       = 12,
  parameter int GUARD      = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               mode,
  input  logic [WIDTH-1:0]   x_in,
  input  logic [WIDTH-1:0]   y_in,
  input  logic [ANGLE_W-1:0] z_in,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   x_out,
  output logic [WIDTH-1:0]   y_out,
  output logic [ANGLE_W-1:0] z_out
);

  localparam int XW = WIDTH + 2 * GUARD;
  localparam int ZW = ANGLE_W + 1;
  localparam int CW = $clog2(ITER);

  localparam logic [CW-1:0]        LAST    = CW'(ITER - 1);
  localparam logic signed [ZW-1:0] QUARTER = ZW'(deg90(ANGLE_FRAC));
  localparam logic signed [XW-1:0] SAT_MAX = XW'((1 << (WIDTH - 1)) - 1);
  localparam logic signed [XW-1:0] SAT_MIN = ~SAT_MAX;

  state_t                state_q, state_d;
  logic                  mode_q, mode_d;
  logic signed [XW-1:0]  x_q, x_d, y_q, y_d;
  logic signed [ZW-1:0]  z_q, z_d;
  logic [CW-1:0]         count_q, count_d;
  logic [WIDTH-1:0]      xo_q, xo_d, yo_q, yo_d;
  logic [ANGLE_W-1:0]    zo_q, zo_d;
  logic                  done_q, done_d;

  logic signed [XW-1:0]  xIn, yIn, xShift, yShift;
  logic signed [ZW-1:0]  zIn, atanI;
  logic                  dirPos;

  // Drop the guard LSBs, then clamp into the output range.
  function automatic logic [WIDTH-1:0] saturate(input logic signed [XW-1:0] v);
    logic signed [XW-1:0] t;
    t = v >>> GUARD;
    if (t > SAT_MAX)      return SAT_MAX[WIDTH-1:0];
    else if (t < SAT_MIN) return SAT_MIN[WIDTH-1:0];
    else                  return t[WIDTH-1:0];
  endfunction

  // Inputs widened with headroom above and fractional guard bits below.
  assign xIn = XW'($signed(x_in)) <<< GUARD;
  assign yIn = XW'($signed(y_in)) <<< GUARD;
  assign zIn = ZW'($signed(z_in));

  assign xShift = x_q >>> count_q;
  assign yShift = y_q >>> count_q;
  assign dirPos = (mode_q == VEC) ? y_q[XW-1] : ~z_q[ZW-1];

  cordic_atan_rom #(
    .ANGLE_W    (ANGLE_W),
    .ANGLE_FRAC (ANGLE_FRAC),
    .CNT_W      (CW)
  ) uAtanRom (
    .count_i (count_q),
    .atan_o  (atanI)
  );

  // Controller and datapath next-state: latch/pre-rotate, iterate, publish.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    count_d = count_q;
    xo_d    = xo_q;
    yo_d    = yo_q;
    zo_d    = zo_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          mode_d  = mode;
          count_d = '0;
          x_d     = xIn;
          y_d     = yIn;
          z_d     = zIn;
          if (mode == ROT) begin
            if (zIn > QUARTER) begin
              x_d = -yIn;
              y_d = xIn;
              z_d = zIn - QUARTER;
            end else if (zIn < -QUARTER) begin
              x_d = yIn;
              y_d = -xIn;
              z_d = zIn + QUARTER;
            end
          end else if (xIn[XW-1]) begin
            if (!yIn[XW-1]) begin
              x_d = yIn;
              y_d = -xIn;
              z_d = zIn + QUARTER;
            end else begin
              x_d = -yIn;
              y_d = xIn;
              z_d = zIn - QUARTER;
            end
          end
        end
      end
      RUN: begin
        if (dirPos) begin
          x_d = x_q - yShift;
          y_d = y_q + xShift;
          z_d = z_q - atanI;
        end else begin
          x_d = x_q + yShift;
          y_d = y_q - xShift;
          z_d = z_q + atanI;
        end
        count_d = count_q + CW'(1);
        if (count_q == LAST) state_d = DONE;
      end
      DONE: begin
        xo_d    = saturate(x_q);
        yo_d    = saturate(y_q);
        zo_d    = z_q[ANGLE_W-1:0];
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset aborts any operation and clears the outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mode_q  <= ROT;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      count_q <= '0;
      xo_q    <= '0;
      yo_q    <= '0;
      zo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      count_q <= count_d;
      xo_q    <= xo_d;
      yo_q    <= yo_d;
      zo_q    <= zo_d;
      done_q  <= done_d;
    end
  end

  assign busy  = (state_q != IDLE);
  assign done  = done_q;
  assign x_out = xo_q;
  assign y_out = yo_q;
  assign z_out = zo_q;

endmodule

// File: doc/cordic_iter.md
# cordic_iter

Parametrised iterative circular CORDIC engine, successor to the team's fixed 16-bit rotation-only CORDIC. Supports rotation and vectoring modes, a full ±180° angle range via quadrant pre-rotation, a start/busy/done handshake, and saturating outputs. It sits between the angle/vector producers and the DSP datapath. One iteration is performed per clock.

## Interface
- WIDTH, 16: signed width of x/y inputs and outputs.
- ANGLE_W, 18: signed width of the angle input/output, in degrees.
- ANGLE_FRAC, 8: fractional bits of the angle (45° = 11520).
- ITER, 12: number of micro-rotations, 4..16.
- GUARD, 2: extra LSB/MSB guard bits on the internal x/y datapath.

Ports:
- clk  in  1: single clock; all state is updated on its rising edge.
- rst_n  in  1: reset, asynchronous and active-low.
- start  in  1: request; sampled only while busy=0.
- mode  in  1: 0 = rotation (drive z to 0), 1 = vectoring (drive y to 0).
- x_in, y_in  in  WIDTH: signed vector.
- z_in  in  ANGLE_W: signed angle. Valid range is −180°..+180°.
- busy  out  1: operation in progress.
- done  out  1: one-cycle pulse when results update.
- x_out, y_out  out  WIDTH: signed results, saturated; CORDIC gain K≈1.6468 is not compensated.
- z_out  out  ANGLE_W: residual angle (rotation mode) or accumulated angle (vectoring mode).

## Operation
- States are IDLE, RUN and DONE. Reset puts the block in IDLE with busy=0, done=0, and x_out/y_out/z_out=0.
- IDLE: start=1 at edge E0 latches mode and pre-rotates the inputs, sets count=0, busy=1, and moves to RUN. The pre-rotation is:
  - Rotation mode, z>90°: x=−y, y=x, z−=90°.
  - Rotation mode, z<−90°: x=y, y=−x, z+=90°.
  - Vectoring mode, x<0 and y≥0: x=y, y=−x, z+=90°.
  - Vectoring mode, x<0 and y<0: x=−y, y=x, z−=90°.
- RUN: on each edge, apply iteration i=count, then count++. After iteration ITER−1, move to DONE.
  - Direction d=+1 if (rotation: z≥0) or (vectoring: y<0), else d=−1.
  - x'=x−d·(y>>>i); y'=y+d·(x>>>i); z'=z−d·atan_i.
- DONE: one edge registers the saturated outputs, asserts done for one cycle, clears busy, and returns to IDLE.
- Arithmetic:
  - x/y are held internally as WIDTH+2·GUARD bits: inputs are sign-extended by GUARD bits and left-shifted by GUARD bits.
  - Shifts are arithmetic; there is no rounding.
  - Outputs drop the GUARD LSBs, then saturate to [−2^(WIDTH−1), 2^(WIDTH−1)−1].
  - z uses ANGLE_W+1 bits internally and wraps silently.
- start while busy=1 is ignored; it is not queued.
- Outputs hold their last values until the next done.
- Reset asserted mid-operation aborts immediately: outputs return to 0 and no done is produced.

## Timing
- Latency: start sampled at E0 → done is high in the cycle after edge E(ITER+1).
- busy is high from after E0 until done rises; it falls in the same cycle done rises.
- Throughput is one operation per ITER+2 cycles. A start presented while done=1 is accepted, because the state is already IDLE.
- mode and inputs only need to be stable at E0.

## Structure
- Package cordic_pkg holds:
  - Mode encoding constants ROT=0 and VEC=1.
  - Parameter-independent atan table: atan(2^−i) in degrees, stored at 24 fractional bits for i=0..15 and right-shifted to ANGLE_FRAC at elaboration.
  - 90° constant expressed in ANGLE_FRAC.
- Sub-module cordic_atan_rom: combinational lookup of atan_i from count, with widths sized by ANGLE_W and ANGLE_FRAC.

## Test plan
- Rotation, x=155, y=0, z=11520 (45°), ITER=12 → done at ITER+2 cycles after start; x_out≈y_out≈180 (±2 LSB); z_out within ±1° of 0.
- Rotation, x=155, y=0, z=30720 (120°) → pre-rotation taken; x_out≈−128, y_out≈221 (±3 LSB).
- Vectoring, x=100, y=100, z=0 → x_out≈233, y_out≈0 (±2), z_out≈11520 (±64). Repeat with x=−100, y=100 → z_out≈34560 (135°).
- Saturation: vectoring, x=y=30000 → x_out=32767, no wrap to negative.
- Handshake: start pulsed again mid-RUN → ignored, single done; back-to-back start during done cycle → accepted, second done ITER+2 cycles later.
- Reset mid-RUN at count=5 → outputs 0, busy=0, no done; next start completes normally.
